ram_master: RTL

Initiator-side memory access unit that drives the synchronous byte-enable RAM port on behalf of the core's load/store path. It accepts one load or store per handshake (byte, half or word; signed or unsigned loads) and formats write lanes and byte enables. It sequences the RAM's one-cycle registered read latency and returns an extended 32-bit result on a valid/ready response channel. It sits between the core's LSU request and the `ram_memory` port (`wen`/`addr`/`wdata`/`rdata`).

---
 rtl/ram_master.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/ram_master.sv
// Load/store initiator for a synchronous byte-enable RAM with one-cycle registered read.
// Define RAM_MASTER_ALIGN_CHECK_EN to fault misaligned/illegal-size requests instead of aligning them.
module ram_master #(
    parameter int unsigned WORD_ADDR_W = 22
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_error,
    output logic [3:0]             mem_wen,
    output logic [WORD_ADDR_W-1:0] mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    logic [1:0]             state_q, state_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_error_q, rsp_error_d;
    logic [3:0]             mem_wen_q, mem_wen_d;
    logic [WORD_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;
    logic                   write_q, write_d;
    logic                   signed_q, signed_d;
    logic [1:0]             size_q, size_d;
    logic [1:0]             off_q, off_d;

    logic                   req_fault_c;
    logic [1:0]             req_size_c;
    logic [1:0]             req_off_c;
    logic [3:0]             req_wen_c;
    logic [31:0]            req_wdata_c;
    logic [7:0]             byte_lane_c;
    logic [15:0]            half_lane_c;
    logic [31:0]            load_ext_c;
    logic                   unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:WORD_ADDR_W+2];

    // Request classification: fault detection or forced alignment, depending on build.
    always_comb begin
        req_size_c  = req_size;
        req_off_c   = req_addr[1:0];
        req_fault_c = 1'b0;
`ifdef RAM_MASTER_ALIGN_CHECK_EN
        case (req_size)
            SZ_HALF: req_fault_c = req_addr[0];
            SZ_WORD: req_fault_c = (req_addr[1:0] != 2'b00);
            SZ_ILL:  req_fault_c = 1'b1;
            default: req_fault_c = 1'b0;
        endcase
`else
        case (req_size)
            SZ_HALF: req_off_c = {req_addr[1], 1'b0};
            SZ_WORD: req_off_c = 2'b00;
            SZ_ILL: begin
                req_size_c = SZ_WORD;
                req_off_c  = 2'b00;
            end
            default: req_off_c = req_addr[1:0];
        endcase
`endif
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        case (req_size_c)
            SZ_BYTE: begin
                req_wen_c   = 4'b0001 << req_off_c;
                req_wdata_c = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                req_wen_c   = req_off_c[1] ? 4'b1100 : 4'b0011;
                req_wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                req_wen_c   = 4'b1111;
                req_wdata_c = req_wdata;
            end
        endcase
    end

    // Load lane select and extension from the registered RAM read data.
    always_comb begin
        case (off_q)
            2'd0:    byte_lane_c = mem_rdata[7:0];
            2'd1:    byte_lane_c = mem_rdata[15:8];
            2'd2:    byte_lane_c = mem_rdata[23:16];
            default: byte_lane_c = mem_rdata[31:24];
        endcase
        half_lane_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_ext_c = {{24{signed_q & byte_lane_c[7]}}, byte_lane_c};
            SZ_HALF: load_ext_c = {{16{signed_q & half_lane_c[15]}}, half_lane_c};
            default: load_ext_c = mem_rdata;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        mem_wen_d   = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        write_d     = write_q;
        signed_d    = signed_q;
        size_d      = size_q;
        off_d       = off_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    write_d     = req_write;
                    signed_d    = req_signed;
                    size_d      = req_size_c;
                    off_d       = req_off_c;
                    if (req_fault_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = req_addr[WORD_ADDR_W+1:2];
                        if (req_write) begin
                            mem_wen_d   = req_wen_c;
                            mem_wdata_d = req_wdata_c;
                        end
                    end
                end
            end
            ACCESS: begin
                if (write_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b0;
                rsp_rdata_d = load_ext_c;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
            mem_wen_q   <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= SZ_BYTE;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            write_q     <= write_d;
            signed_q    <= signed_d;
            size_q      <= size_d;
            off_q       <= off_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef RAM_MASTER_ALIGN_CHECK_EN
    assign rsp_error = rsp_error_q;
`else
    assign rsp_error = 1'b0;
    logic unused_rsp_error;
    assign unused_rsp_error = rsp_error_q;
`endif

endmodule
